// File: rtl/polyveck_pack_hint.sv
// Packs a K x N hint vector into an OMEGA+K byte stream: index bytes, zero padding, cumulative counts.
// Define PACK_HINT_OMEGA_CHECK_EN to abort with err on more than OMEGA hints instead of saturating.
module polyveck_pack_hint #(
    parameter int K     = 6,
    parameter int N     = 256,
    parameter int OMEGA = 55
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [K*N*32-1:0] h_in,
    output logic              busy,
    output logic [7:0]        out_byte,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              done,
    output logic              err
);

    localparam int IW = $clog2(K + 1);
    localparam int CW = $clog2(K);
    localparam int JW = $clog2(N);
    localparam int KW = $clog2(OMEGA + 1);

    typedef enum logic [2:0] {IDLE, SCAN, PAD, CNT, DONE} state_t;

    state_t            state_q, state_d;
    logic [K*N*32-1:0] h_q, h_d;
    logic [IW-1:0]     i_q, i_d;
    logic [JW-1:0]     j_q, j_d;
    logic [KW-1:0]     k_q, k_d;
    logic [KW-1:0]     cnt_q [K];
    logic [KW-1:0]     cnt_d [K];
    logic [7:0]        byte_q, byte_d;
    logic              valid_q, valid_d;
    logic              err_q, err_d;

    logic              slot_free;
    logic              coef_nz;
    logic              last_j;
    logic              last_i;
    logic [CW-1:0]     ci;
    logic [KW-1:0]     k_cur;

    // The output register may be reloaded whenever it is empty or being accepted this cycle.
    assign slot_free = !valid_q || out_ready;
    // Coefficients are consumed from the bottom of a shifting copy of h_in, so (i,j) is always h_q[31:0].
    assign coef_nz   = |h_q[31:0];
    assign last_j    = (j_q == JW'(N - 1));
    assign last_i    = (i_q == IW'(K - 1));
    assign ci        = i_q[CW-1:0];

    always_comb begin
        state_d = state_q;
        h_d     = h_q;
        i_d     = i_q;
        j_d     = j_q;
        k_d     = k_q;
        cnt_d   = cnt_q;
        byte_d  = byte_q;
        valid_d = valid_q;
        err_d   = err_q;
        k_cur   = k_q;

        if (slot_free) begin
            valid_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (start) begin
                    h_d     = h_in;
                    i_d     = '0;
                    j_d     = '0;
                    k_d     = '0;
                    err_d   = 1'b0;
                    state_d = SCAN;
                end
            end
            SCAN: begin
                if (slot_free) begin
                    h_d = h_q >> 32;
                    j_d = last_j ? '0 : j_q + 1'b1;
                    if (coef_nz && (k_q != KW'(OMEGA))) begin
                        byte_d  = 8'(j_q);
                        valid_d = 1'b1;
                        k_cur   = k_q + 1'b1;
                    end
                    k_d = k_cur;
                    if (last_j) begin
                        cnt_d[ci] = k_cur;
                        i_d       = i_q + 1'b1;
                        if (last_i) begin
                            state_d = PAD;
                        end
                    end
`ifdef PACK_HINT_OMEGA_CHECK_EN
                    if (coef_nz && (k_q == KW'(OMEGA))) begin
                        err_d   = 1'b1;
                        state_d = DONE;
                    end
`endif
                end
            end
            PAD: begin
                // k keeps counting index-region bytes here so padding stops at exactly OMEGA.
                if (slot_free) begin
                    valid_d = 1'b1;
                    if (k_q < KW'(OMEGA)) begin
                        byte_d = 8'h00;
                        k_d    = k_q + 1'b1;
                    end else begin
                        byte_d  = 8'(cnt_q[0]);
                        i_d     = IW'(1);
                        state_d = CNT;
                    end
                end
            end
            CNT: begin
                if (slot_free) begin
                    if (i_q == IW'(K)) begin
                        state_d = DONE;
                    end else begin
                        byte_d  = 8'(cnt_q[ci]);
                        valid_d = 1'b1;
                        i_d     = i_q + 1'b1;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            i_q     <= '0;
            j_q     <= '0;
            k_q     <= '0;
            cnt_q   <= '{default: '0};
            byte_q  <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            i_q     <= i_d;
            j_q     <= j_d;
            k_q     <= k_d;
            cnt_q   <= cnt_d;
            byte_q  <= byte_d;
            valid_q <= valid_d;
            err_q   <= err_d;
        end
    end

    always_ff @(posedge clk) begin
        h_q <= h_d;
    end

    assign busy      = (state_q != IDLE);
    assign done      = (state_q == DONE);
    assign out_byte  = byte_q;
    assign out_valid = valid_q;
    assign err       = err_q;

endmodule

// File: tb/tb_polyveck_pack_hint.sv
// Directed bench for polyveck_pack_hint; expected frames are written out by hand.
module tb_polyveck_pack_hint;

    localparam int K     = 6;
    localparam int N     = 256;
    localparam int OMEGA = 55;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic              out_ready;
    logic              busy;
    logic              out_valid;
    logic              done;
    logic              err;
    logic [7:0]        out_byte;
    logic [K*N*32-1:0] h_in;
    logic [K*N*32-1:0] h;

    int         errors = 0;
    int         checks = 0;
    logic [7:0] rx[$];
    logic [7:0] exp_q[$];
    bit         got_done;
    bit         got_err;
    bit         seen_done;

    polyveck_pack_hint #(.K(K), .N(N), .OMEGA(OMEGA)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .h_in      (h_in),
        .busy      (busy),
        .out_byte  (out_byte),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    task automatic setc(input int i, input int j, input logic [31:0] v);
        h[32*(N*i+j) +: 32] = v;
    endtask

    task automatic compare_frame(input string tag);
        check({tag, "_len"}, rx.size(), exp_q.size());
        for (int n = 0; n < exp_q.size() && n < rx.size(); n++)
            check($sformatf("%s_b%0d", tag, n), rx[n], exp_q[n]);
    endtask

    function automatic void exp_two_hints();
        exp_q.delete();
        exp_q.push_back(8'h03);
        exp_q.push_back(8'hFF);
        repeat (53) exp_q.push_back(8'h00);
        exp_q.push_back(8'h01); exp_q.push_back(8'h01);
        exp_q.push_back(8'h02); exp_q.push_back(8'h02);
        exp_q.push_back(8'h02); exp_q.push_back(8'h02);
    endfunction

    // Drives one frame from start to done, collecting accepted bytes.
    // rnd: hold out_ready low 10 cycles while byte 1 is presented, then randomize it.
    task automatic run_frame(input bit rnd);
        int         hold = 0;
        bit         hold_done = 0;
        bit         stalled = 0;
        bit         r;
        logic [7:0] pb = '0;
        rx.delete();
        got_done = 0;
        got_err  = 0;
        h_in = h;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        for (int cyc = 0; cyc < 6000; cyc++) begin
            if (stalled) begin
                check("stall_byte", out_byte, pb);
                check("stall_valid", out_valid, 1);
            end
            if (done) begin
                got_done = 1;
                got_err  = err;
                break;
            end
            r = 1'b1;
            if (rnd) begin
                if (!hold_done && out_valid && rx.size() == 1) begin
                    if (hold < 10) begin
                        r = 1'b0;
                        hold++;
                    end else begin
                        hold_done = 1;
                    end
                end else if (hold_done) begin
                    r = 1'($urandom_range(0, 1));
                end
            end
            out_ready = r;
            stalled   = out_valid && !r;
            pb        = out_byte;
            if (out_valid && r) rx.push_back(out_byte);
            @(negedge clk);
        end
        out_ready = 1'b1;
        if (!got_done) check("done_timeout", 0, 1);
    endtask

    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        out_ready = 1'b1;
        h         = '0;
        h_in      = '0;
        repeat (3) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_valid", out_valid, 0);
        check("rst_byte", out_byte, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        rst = 1'b0;

        // All-zero hint vector
        h = '0;
        run_frame(0);
        exp_q.delete();
        repeat (61) exp_q.push_back(8'h00);
        compare_frame("zero");
        check("zero_done", got_done, 1);
        check("zero_err", got_err, 0);
        @(negedge clk);
        check("zero_done_pulse", done, 0);
        check("zero_idle", busy, 0);

        // Two hints: (0,3) and (2,255)
        h = '0;
        setc(0, 3, 32'h1);
        setc(2, 255, 32'h1);
        run_frame(0);
        exp_two_hints();
        compare_frame("two");
        check("two_err", got_err, 0);

        // Exactly OMEGA hints in poly 5
        h = '0;
        for (int j = 0; j < 55; j++) setc(5, j, (j % 2 == 1) ? 32'h8000_0000 : 32'(j + 1));
        run_frame(0);
        exp_q.delete();
        for (int j = 0; j < 55; j++) exp_q.push_back(8'(j));
        repeat (5) exp_q.push_back(8'h00);
        exp_q.push_back(8'h37);
        compare_frame("full");
        check("full_err", got_err, 0);

        // OMEGA+1 hints
        setc(5, 55, 32'h0001_0000);
        run_frame(0);
        exp_q.delete();
        for (int j = 0; j < 55; j++) exp_q.push_back(8'(j));
`ifdef PACK_HINT_OMEGA_CHECK_EN
        compare_frame("over");
        check("over_err", got_err, 1);
        repeat (3) @(negedge clk);
        check("over_err_hold", err, 1);
`else
        repeat (5) exp_q.push_back(8'h00);
        exp_q.push_back(8'h37);
        compare_frame("over");
        check("over_err", got_err, 0);
`endif

        // Backpressure: same stream as the two-hint frame
        h = '0;
        setc(0, 3, 32'h1);
        setc(2, 255, 32'h1);
        run_frame(1);
        exp_two_hints();
        compare_frame("stall");
        check("stall_err", got_err, 0);

        // Reset in the middle of SCAN
        h_in = h;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        repeat (699) @(negedge clk);
        check("mid_busy_pre", busy, 1);
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_valid", out_valid, 0);
        check("mid_rst_byte", out_byte, 0);
        check("mid_rst_done", done, 0);
        check("mid_rst_err", err, 0);
        rst = 1'b0;
        seen_done = 0;
        repeat (20) begin
            @(negedge clk);
            if (done) seen_done = 1;
        end
        check("mid_no_done", seen_done, 0);
        run_frame(0);
        exp_two_hints();
        compare_frame("after_rst");
        check("after_rst_err", got_err, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
